// File: rtl/calculator_pkg.sv
// calculator_pkg: shared calculator widths plus the word unpacker's state and half-select types.
package calculator_pkg;
  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} unpack_state_t;
  typedef logic half_sel_t;
  localparam half_sel_t LOWER_HALF = 1'b0;
  localparam half_sel_t UPPER_HALF = 1'b1;
endpackage

// File: rtl/word_unpacker.sv
// word_unpacker: replays one memory word as lower then upper DATA_W halves over valid/ready.
// Optional completed-word counter on words_done_o when UNPACK_WORD_CNT_EN is defined.
module word_unpacker #(
  parameter int DATA_W        = calculator_pkg::DATA_W,
  parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     word_valid_i,
  output logic                     word_ready_o,
  input  logic [MEM_WORD_SIZE-1:0] word_i,
  input  logic                     flush_i,
  output logic                     half_valid_o,
  input  logic                     half_ready_i,
  output logic [DATA_W-1:0]        half_o,
  output logic                     loc_sel_o,
  output logic                     last_o,
  output logic                     busy_o
`ifdef UNPACK_WORD_CNT_EN
  , output logic [15:0]            words_done_o
`endif
);
  import calculator_pkg::*;
  if (MEM_WORD_SIZE != 2 * DATA_W) begin : g_width_chk
    $error("word_unpacker: MEM_WORD_SIZE must equal 2*DATA_W");
  end
  unpack_state_t state_q, state_d;
  logic [MEM_WORD_SIZE-1:0] held_q;
  logic half_hs, word_hs;
  assign half_hs      = half_valid_o && half_ready_i;
  assign word_ready_o = !flush_i && (state_q == IDLE || (state_q == HIGH && half_ready_i));
  assign word_hs      = word_valid_i && word_ready_o;
  always_comb begin
    state_d = flush_i            ? IDLE :
              (state_q == IDLE)  ? (word_hs ? LOW : IDLE) :
              (state_q == LOW)   ? (half_hs ? HIGH : LOW) :
              half_hs            ? (word_hs ? LOW : IDLE) : HIGH;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      if (word_hs) held_q <= word_i;
    end
  end
  assign half_valid_o = (state_q != IDLE);
  assign busy_o       = (state_q != IDLE);
  assign loc_sel_o    = (state_q == HIGH) ? UPPER_HALF : LOWER_HALF;
  assign last_o       = (state_q == HIGH);
  assign half_o       = (state_q == LOW)  ? held_q[DATA_W-1:0] :
                        (state_q == HIGH) ? held_q[MEM_WORD_SIZE-1:DATA_W] : '0;
`ifdef UNPACK_WORD_CNT_EN
  // flush wins over the upper handshake, so dropped words are never counted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) words_done_o <= '0;
    else if (state_q == HIGH && half_ready_i && !flush_i) words_done_o <= words_done_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_word_unpacker.sv
// tb_word_unpacker: scoreboard bench; stimulus queues expected halves, a negedge monitor checks them.
module tb_word_unpacker;
  typedef struct {logic [31:0] d; logic sel; logic last;} exp_t;
  logic clk = 0, rst_ni = 0;
  logic word_valid = 0, flush = 0, half_ready = 0;
  logic [63:0] word = '0;
  logic word_ready, half_valid, loc_sel, last, busy;
  logic [31:0] half;
`ifdef UNPACK_WORD_CNT_EN
  logic [15:0] words_done;
  int exp_cnt = 0;
`endif
  exp_t sb[$];
  int pre_n = 0;
  bit exp_ready = 1, mon_en = 0;
  int checks = 0, errors = 0;

  word_unpacker dut (
    .clk_i(clk), .rst_ni(rst_ni), .word_valid_i(word_valid), .word_ready_o(word_ready),
    .word_i(word), .flush_i(flush), .half_valid_o(half_valid), .half_ready_i(half_ready),
    .half_o(half), .loc_sel_o(loc_sel), .last_o(last), .busy_o(busy)
`ifdef UNPACK_WORD_CNT_EN
    , .words_done_o(words_done)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bench cycle: drive after the edge, then book the model's view before the monitor samples.
  task automatic cyc(input bit v, input logic [63:0] w, input bit hr, input bit fl);
    @(posedge clk);
    #1;
    word_valid = v; word = w; half_ready = hr; flush = fl;
    #3;
    pre_n = sb.size();
    exp_ready = !fl && (pre_n == 0 || (pre_n == 1 && hr));
    if (v && exp_ready) begin
      sb.push_back('{w[31:0], 1'b0, 1'b0});
      sb.push_back('{w[63:32], 1'b1, 1'b1});
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_ni) begin
      chk("word_ready", word_ready, exp_ready);
      chk("half_valid", half_valid, pre_n > 0);
      chk("busy", busy, pre_n > 0);
      if (pre_n > 0) begin
        chk("half", half, sb[0].d);
        chk("loc_sel", loc_sel, sb[0].sel);
        chk("last", last, sb[0].last);
      end else chk("half_idle", half, 0);
`ifdef UNPACK_WORD_CNT_EN
      chk("words_done", words_done, exp_cnt);
`endif
      if (flush) begin
        sb.delete();
        pre_n = 0;
      end else if (pre_n > 0 && half_ready) begin
`ifdef UNPACK_WORD_CNT_EN
        if (sb[0].last) exp_cnt = (exp_cnt + 1) % 65536;
`endif
        void'(sb.pop_front());
        pre_n--;
      end
    end
  end

  initial begin
    #3;
    chk("rst_half_valid", half_valid, 0);
    chk("rst_word_ready", word_ready, 1);
    chk("rst_half", half, 0);
    chk("rst_last", {loc_sel, last, busy}, 0);
    #9 rst_ni = 1;
    mon_en = 1;
    // basic word
    cyc(1, 64'h1122334455667788, 1, 0);
    repeat (3) cyc(0, 0, 1, 0);
    // back-to-back words, ready always high
    cyc(1, 64'hAAAA0001BBBB0002, 1, 0);
    cyc(1, 64'hCCCC0003DDDD0004, 1, 0);
    cyc(1, 64'hCCCC0003DDDD0004, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    // backpressure in LOW
    cyc(1, 64'h1122334455667788, 0, 0);
    repeat (3) cyc(1, 64'hDEADBEEFCAFEF00D, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    // flush in HIGH while a word is offered
    cyc(1, 64'h0123456789ABCDEF, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 64'hFEDCBA9876543210, 1, 1);
    cyc(1, 64'hFEDCBA9876543210, 1, 0);
    repeat (3) cyc(0, 0, 1, 0);
    // randomized traffic
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(9) < 7, {$urandom, $urandom}, $urandom_range(9) < 7, $urandom_range(19) == 0);
    repeat (4) cyc(0, 0, 1, 0);
    chk("drained", sb.size(), 0);
    // async reset while holding the lower half
    cyc(1, 64'h5555AAAA3333CCCC, 0, 0);
    cyc(0, 0, 0, 0);
    @(posedge clk);
    #2;
    mon_en = 0;
    rst_ni = 0;
    #1;
    chk("arst_half_valid", half_valid, 0);
    chk("arst_half", half, 0);
    chk("arst_word_ready", word_ready, 1);
    chk("arst_flags", {loc_sel, last, busy}, 0);
`ifdef UNPACK_WORD_CNT_EN
    chk("arst_words_done", words_done, 0);
    exp_cnt = 0;
`endif
    sb.delete();
    pre_n = 0;
    exp_ready = 1;
    #4 rst_ni = 1;
    mon_en = 1;
    cyc(1, 64'h0F0F0F0FF0F0F0F0, 1, 0);
    repeat (3) cyc(0, 0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
